// File: rtl/trace_pkg.sv
// Shared types and default widths for the logic-analyzer trace capture and
// readout path; the capture core uses the same width constants.
package trace_pkg;

    localparam int TRACE_ADDR_WIDTH = 16;
    localparam int TRACE_DATA_WIDTH = 17;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

endpackage

// File: rtl/trace_skid_fifo.sv
// Two-entry valid/ready FIFO that absorbs trace RAM read returns; its
// occupancy feeds the read-issue credit check in the readout engine.
module trace_skid_fifo
    import trace_pkg::*;
#(
    parameter int WIDTH = TRACE_DATA_WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             pop;

    assign pop       = out_valid && out_ready;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/trace_readout.sv
// Reads the trace RAM oldest-sample-first after capture stops and streams the
// samples out over valid/ready, tagging the final sample with m_last.
module trace_readout
    import trace_pkg::*;
#(
    parameter int ADDR_WIDTH = TRACE_ADDR_WIDTH,
    parameter int DATA_WIDTH = TRACE_DATA_WIDTH
) (
    input  logic                  trig_clk,
    input  logic                  trig_rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] wt_addr,
    input  logic                  wrapped,
    output logic                  rd_ce,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_WIDTH-1:0]  rem_q;
    logic [CNT_WIDTH-1:0]  start_count;
    logic [ADDR_WIDTH-1:0] start_base;
    logic                  inflight_q;
    logic                  inflight_last_q;
    logic                  done_q;

    logic                  issue;
    logic                  last_issue;
    logic                  pop;
    logic                  credit_ok;
    logic [2:0]            occupied;
    logic                  fifo_valid;
    logic [1:0]            fifo_count;
    logic [DATA_WIDTH:0]   fifo_head;
    logic                  head_last;

    // A wrapped buffer holds a full 2^ADDR_WIDTH samples starting at the write pointer.
    always_comb begin
        start_count = {1'b0, wt_addr};
        start_base  = '0;
        if (wrapped) begin
            start_count = {1'b1, {ADDR_WIDTH{1'b0}}};
            start_base  = wt_addr;
        end
    end

    // The word popped this cycle frees its slot, which keeps streaming bubble-free.
    assign pop        = fifo_valid && m_ready;
    assign occupied   = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign credit_ok  = occupied < (3'd2 + {2'b00, pop});
    assign issue      = (state_q == READ) && credit_ok;
    assign last_issue = issue && (rem_q == CNT_ONE);
    assign head_last  = fifo_valid && fifo_head[DATA_WIDTH];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && (start_count != '0)) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (last_issue) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge trig_clk) begin
        if (trig_rst) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            inflight_q      <= issue;
            inflight_last_q <= last_issue;
            done_q          <= ((state_q == IDLE) && start && (start_count == '0)) ||
                               ((state_q == DRAIN) && pop && head_last);
            if ((state_q == IDLE) && start) begin
                addr_q <= start_base;
                rem_q  <= start_count;
            end else if (issue) begin
                addr_q <= addr_q + ADDR_ONE;
                rem_q  <= rem_q - CNT_ONE;
            end
        end
    end

    // The last-sample tag travels with the data through the FIFO.
    trace_skid_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk       (trig_clk),
        .rst       (trig_rst),
        .push      (inflight_q),
        .push_data ({inflight_last_q, rd_data}),
        .out_valid (fifo_valid),
        .out_ready (m_ready),
        .out_data  (fifo_head),
        .count     (fifo_count)
    );

    assign rd_ce   = issue;
    assign rd_addr = addr_q;
    assign m_valid = fifo_valid;
    assign m_data  = fifo_head[DATA_WIDTH-1:0];
    assign m_last  = head_last;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

endmodule

// File: tb/tb_trace_readout.sv
// Directed self-checking bench for trace_readout with a 16-entry trace RAM model.
module tb_trace_readout;

    localparam int AW = 4;
    localparam int DW = 17;

    logic          trig_clk = 1'b0;
    logic          trig_rst;
    logic          start;
    logic [AW-1:0] wt_addr;
    logic          wrapped;
    logic          rd_ce;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] ram [16];

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] data_log [$];
    logic          last_log [$];
    int            rd_ce_cnt       = 0;
    int            done_cnt        = 0;
    int            stall_err       = 0;
    int            outstanding     = 0;
    int            max_outstanding = 0;
    logic          prev_stall      = 1'b0;
    logic [DW-1:0] prev_data       = '0;
    bit            seen;

    always #5 trig_clk = ~trig_clk;

    trace_readout #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .trig_clk (trig_clk),
        .trig_rst (trig_rst),
        .start    (start),
        .wt_addr  (wt_addr),
        .wrapped  (wrapped),
        .rd_ce    (rd_ce),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .busy     (busy),
        .done     (done)
    );

    function automatic logic [DW-1:0] word(input int a);
        return 17'h10000 + 17'(a * 'h111);
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) begin
            ram[i] = word(i);
        end
    end

    always @(posedge trig_clk) begin
        if (rd_ce) begin
            rd_data <= ram[rd_addr];
        end
    end

    // Observes each cycle between edges, after the bench has driven its inputs.
    always @(negedge trig_clk) begin
        #3;
        if (trig_rst) begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            if (m_valid && m_ready) begin
                data_log.push_back(m_data);
                last_log.push_back(m_last);
            end
            if (rd_ce) rd_ce_cnt++;
            if (done) done_cnt++;
            if (prev_stall && !(m_valid && (m_data === prev_data))) stall_err++;
            prev_stall  = m_valid && !m_ready;
            prev_data   = m_data;
            outstanding = outstanding + int'(rd_ce) - int'(m_valid && m_ready);
            if (outstanding > max_outstanding) max_outstanding = outstanding;
        end
    end

    task automatic step();
        @(negedge trig_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [AW-1:0] wa, input logic wr);
        start   = s;
        wt_addr = wa;
        wrapped = wr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clearLog();
        data_log.delete();
        last_log.delete();
        rd_ce_cnt       = 0;
        done_cnt        = 0;
        stall_err       = 0;
        max_outstanding = 0;
    endtask

    function automatic logic [31:0] dataAt(input int i);
        if (i < data_log.size()) return 32'(data_log[i]);
        return 'x;
    endfunction

    function automatic logic [31:0] lastAt(input int i);
        if (i < last_log.size()) return 32'(last_log[i]);
        return 'x;
    endfunction

    task automatic waitDone(input int budget, output bit hit);
        hit = 0;
        for (int c = 0; c < budget && !hit; c++) begin
            step();
            if (done) hit = 1;
        end
    endtask

    task automatic checkSequence(input string tag, input int n, input int base);
        checkOutput({tag, " count"}, data_log.size(), n);
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s data %0d", tag, i), dataAt(i), word((base + i) % 16));
            checkOutput($sformatf("%s last %0d", tag, i), lastAt(i), 32'(i == n - 1));
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " rd_ce"},   rd_ce,   0);
        checkOutput({tag, " rd_addr"}, rd_addr, 0);
        checkOutput({tag, " m_valid"}, m_valid, 0);
        checkOutput({tag, " m_data"},  m_data,  0);
        checkOutput({tag, " m_last"},  m_last,  0);
        checkOutput({tag, " busy"},    busy,    0);
        checkOutput({tag, " done"},    done,    0);
    endtask

    initial begin
        trig_rst = 1'b1;
        m_ready  = 1'b1;
        applyStimulus(1'b0, 4'd0, 1'b0);
        step();
        step();
        checkResetOutputs("reset");
        trig_rst = 1'b0;
        step();

        // Non-wrapped, five samples, no backpressure: exact cycle timing.
        clearLog();
        applyStimulus(1'b1, 4'd5, 1'b0);
        step();
        start = 1'b0;
        checkOutput("nw T+1 busy", busy, 1);
        checkOutput("nw T+1 rd_ce", rd_ce, 1);
        checkOutput("nw T+1 rd_addr", rd_addr, 0);
        checkOutput("nw T+1 m_valid", m_valid, 0);
        step();
        checkOutput("nw T+2 rd_ce", rd_ce, 1);
        checkOutput("nw T+2 rd_addr", rd_addr, 1);
        checkOutput("nw T+2 m_valid", m_valid, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            checkOutput($sformatf("nw T+%0d m_valid", k + 3), m_valid, 1);
            checkOutput($sformatf("nw T+%0d m_data", k + 3), m_data, word(k));
            checkOutput($sformatf("nw T+%0d m_last", k + 3), m_last, 32'(k == 4));
            checkOutput($sformatf("nw T+%0d done", k + 3), done, 0);
        end
        step();
        checkOutput("nw T+8 done", done, 1);
        checkOutput("nw T+8 busy", busy, 0);
        checkOutput("nw T+8 m_valid", m_valid, 0);
        step();
        checkOutput("nw T+9 done", done, 0);
        checkOutput("nw rd_ce count", rd_ce_cnt, 5);
        checkOutput("nw done count", done_cnt, 1);
        checkOutput("nw max outstanding", max_outstanding, 2);

        // Wrapped buffer: 16 samples starting at the write pointer.
        clearLog();
        applyStimulus(1'b1, 4'd3, 1'b1);
        step();
        start = 1'b0;
        waitDone(80, seen);
        checkOutput("wrap done seen", 32'(seen), 1);
        step();
        step();
        checkSequence("wrap", 16, 3);
        checkOutput("wrap done count", done_cnt, 1);

        // Backpressure with a ten-cycle stall followed by random ready.
        clearLog();
        applyStimulus(1'b1, 4'd8, 1'b0);
        step();
        start = 1'b0;
        seen  = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            if (c >= 4 && c < 14) m_ready = 1'b0;
            else                  m_ready = 1'($urandom_range(0, 1));
            step();
            if (done) seen = 1;
        end
        m_ready = 1'b1;
        checkOutput("bp done seen", 32'(seen), 1);
        step();
        step();
        checkSequence("bp", 8, 0);
        checkOutput("bp stall stability", stall_err, 0);
        checkOutput("bp max outstanding", max_outstanding, 2);
        checkOutput("bp done count", done_cnt, 1);

        // Empty buffer completes immediately without reading.
        clearLog();
        applyStimulus(1'b1, 4'd0, 1'b0);
        step();
        start = 1'b0;
        checkOutput("empty T+1 done", done, 1);
        checkOutput("empty T+1 busy", busy, 0);
        checkOutput("empty T+1 rd_ce", rd_ce, 0);
        checkOutput("empty T+1 m_valid", m_valid, 0);
        step();
        checkOutput("empty T+2 done", done, 0);
        step();
        checkOutput("empty rd_ce count", rd_ce_cnt, 0);
        checkOutput("empty m_valid count", data_log.size(), 0);

        // Reset during READ after three samples, then a full replay.
        clearLog();
        applyStimulus(1'b1, 4'd10, 1'b0);
        step();
        start = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            checkOutput($sformatf("rst pre data %0d", k), m_data, word(k));
        end
        trig_rst = 1'b1;
        step();
        checkResetOutputs("midrst");
        trig_rst = 1'b0;
        clearLog();
        applyStimulus(1'b1, 4'd10, 1'b0);
        step();
        start = 1'b0;
        waitDone(80, seen);
        checkOutput("replay done seen", 32'(seen), 1);
        step();
        checkSequence("replay", 10, 0);
        checkOutput("replay done count", done_cnt, 1);

        // Start pulsed while busy must be ignored.
        clearLog();
        applyStimulus(1'b1, 4'd6, 1'b0);
        step();
        start = 1'b0;
        step();
        step();
        applyStimulus(1'b1, 4'd2, 1'b1);
        step();
        applyStimulus(1'b0, 4'd0, 1'b0);
        waitDone(60, seen);
        checkOutput("busy-start done seen", 32'(seen), 1);
        repeat (5) step();
        checkSequence("busy-start", 6, 0);
        checkOutput("busy-start done count", done_cnt, 1);
        checkOutput("busy-start busy after", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/trace_readout.md
# trace_readout

Readout engine for the embedded logic-analyzer trace memory. The capture core writes samples through `wt_ce`/`wt_en`/`wt_addr`; this block is the other end. After capture stops, it reads the trace RAM in chronological order (oldest sample first) and presents each sample on a valid/ready stream toward the host-side serializer. It sits between the trace RAM read port and the debug upload path, in the trigger clock domain.

## Interface
- `ADDR_WIDTH`, 16, trace RAM address width; matches `wt_addr`.
- `DATA_WIDTH`, 17, sample width (2 non-bus + 15 bus nodes).

- `trig_clk`  in  1  sole clock.
- `trig_rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  single-cycle request to begin readout; ignored while `busy`.
- `wt_addr`  in  ADDR_WIDTH  capture write pointer (next address to be written), sampled on accepted `start`.
- `wrapped`  in  1  capture has filled the buffer at least once; sampled with `wt_addr`.
- `rd_ce`  out  1  RAM read enable.
- `rd_addr`  out  ADDR_WIDTH  RAM read address.
- `rd_data`  in  DATA_WIDTH  RAM read data, valid exactly one cycle after `rd_ce`.
- `m_valid`  out  1  output sample valid.
- `m_ready`  in  1  downstream accepts.
- `m_data`  out  DATA_WIDTH  output sample.
- `m_last`  out  1  marks final sample; qualified by `m_valid`.
- `busy`  out  1  readout in progress.
- `done`  out  1  one-cycle pulse when readout completes.

## Operation
- States: IDLE, READ, DRAIN.
- IDLE: `busy`=0. On `start`, latch the count N and the base address:
  - `wrapped`=1: N=2^ADDR_WIDTH, base=`wt_addr`.
  - `wrapped`=0: N=`wt_addr`, base=0.
  - If N=0: stay IDLE and pulse `done` next cycle; no `m_valid`.
  - Otherwise go to READ.
- READ: issue `rd_ce` with `rd_addr`=base+k (mod 2^ADDR_WIDTH), k=0..N-1.
  - Issue only while buffered + in-flight words < 2.
  - Remaining counter is ADDR_WIDTH+1 bits wide (holds 2^ADDR_WIDTH).
  - After the last issue, go to DRAIN.
- DRAIN: wait until the final word handshakes, then return to IDLE and pulse `done`.
- Returned read data enters a 2-entry skid FIFO whose head drives `m_data`/`m_valid`.
  - A word leaves on `m_valid & m_ready`.
  - `m_last`=1 when the head is word N-1.
- `m_data` is held stable while `m_valid & !m_ready`. No sample is lost or duplicated under any `m_ready` pattern.
- `start` while `busy` is ignored; no restart and no re-latch.
- `trig_rst` in any state: return to IDLE, flush FIFO, discard in-flight read, clear counters.

## Timing
- Reset values: `rd_ce`, `rd_addr`, `m_valid`, `m_data`, `m_last`, `busy`, `done` all 0.
- `start` high in cycle T:
  - `busy`=1 and first `rd_ce` in T+1.
  - Data returns in T+2.
  - First `m_valid` in T+3.
- With `m_ready` held at 1, throughput is one sample per cycle with no bubbles after the first.
- `done` is high for exactly one cycle, the cycle after the `m_last` handshake; `busy` drops in that same cycle.
- Empty case (N=0): `done` in T+1; `busy` stays 0.
- `trig_rst` sampled high at an edge: all outputs are at reset values in the following cycle.

## Structure
- Package `trace_pkg` holds:
  - state enum {IDLE, READ, DRAIN};
  - default `ADDR_WIDTH`/`DATA_WIDTH` constants shared with the capture core.
- Sub-module `trace_skid_fifo`: 2-entry valid/ready FIFO with occupancy output, used for the credit check.
- Top level contains the FSM, address generator, remaining counter, in-flight flag and `m_last` tagging.

## Test plan
- Non-wrapped: RAM[i]=i, `wt_addr`=5, `wrapped`=0, `m_ready`=1, `start` at T -> `m_data` 0,1,2,3,4 in T+3..T+7; `m_last` only with 4; `done` at T+8.
- Wrapped (ADDR_WIDTH=4): `wt_addr`=3, `wrapped`=1 -> 16 words from addresses 3..15 then 0..2; `m_last` on the word from address 2.
- Backpressure: N=8, `m_ready` random, including 10 cycles held low -> exact sequence 0..7, `m_data` stable while stalled, never more than 2 words outstanding.
- Empty: `wt_addr`=0, `wrapped`=0 -> no `rd_ce`, no `m_valid`, `done` at T+1.
- Reset mid-READ after 3 samples -> all outputs 0 next cycle; a new `start` replays the full sequence from word 0.
- `start` pulsed while `busy` -> ignored; the original sequence completes unchanged with a single `done`.
